// File: rtl/lift_call_scheduler.sv
// SCAN call scheduler in front of Lift: latches floor calls, dispatches one target at a time, tracks arrival.
// Optional post-arrival door hold is built when LIFT_SCHED_DOOR_HOLD_EN is defined.
module lift_call_scheduler #(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned FLOOR_W     = 3,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned DOOR_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] hall_call,
  input  logic [NUM_FLOORS-1:0] car_call,
  input  logic [FLOOR_W-1:0]    elev_f,
  input  logic                  busy,
  output logic [FLOOR_W-1:0]    pass_f,
  output logic                  butt_up_down,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  sched_idle
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    WAIT_ACK,
    TRAVEL,
    ARRIVE
`ifdef LIFT_SCHED_DOOR_HOLD_EN
    , HOLD
`endif
  } state_e;

  state_e                state_q, state_n;
  logic [NUM_FLOORS-1:0] pending_q, pending_n, clr_mask, floor_oh;
  logic [FLOOR_W-1:0]    pass_f_q, pass_f_n;
  logic                  butt_q, butt_n, dir_q, dir_n, idle_q, idle_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic                  elev_ok, here_pending;
  logic                  up_hit, dn_hit, tgt_dir;
  logic [FLOOR_W-1:0]    up_tgt, dn_tgt, tgt;

`ifdef LIFT_SCHED_DOOR_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(DOOR_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DOOR_HOLD - 1);
  logic [HOLD_W-1:0] hold_q, hold_n;
`else
  logic unused_door_hold;
  assign unused_door_hold = ^32'(DOOR_HOLD);
`endif

  // One-hot of the lift's floor; all-zero when elev_f is out of range.
  always_comb begin : floor_decode
    floor_oh = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      floor_oh[i] = (elev_f == FLOOR_W'(i));
    end
  end

  assign elev_ok      = |floor_oh;
  assign here_pending = |(pending_q & floor_oh);

  // Nearest pending floor above and below the lift; direction rule picks one.
  always_comb begin : scan_select
    up_hit = 1'b0;
    up_tgt = '0;
    dn_hit = 1'b0;
    dn_tgt = '0;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending_q[i] && (FLOOR_W'(i) > elev_f)) begin
        up_hit = 1'b1;
        up_tgt = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending_q[i] && (FLOOR_W'(i) < elev_f)) begin
        dn_hit = 1'b1;
        dn_tgt = FLOOR_W'(i);
      end
    end
    if (dir_q) begin
      tgt     = up_hit ? up_tgt : dn_tgt;
      tgt_dir = up_hit;
    end else begin
      tgt     = dn_hit ? dn_tgt : up_tgt;
      tgt_dir = !dn_hit;
    end
  end

  always_comb begin : fsm_next
    state_n  = state_q;
    clr_mask = '0;
    pass_f_n = pass_f_q;
    dir_n    = dir_q;
    butt_n   = 1'b0;
    cnt_n    = cnt_q;
`ifdef LIFT_SCHED_DOOR_HOLD_EN
    hold_n   = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (elev_ok && !busy) begin
          if (here_pending) begin
            clr_mask = floor_oh;
          end else if (|pending_q) begin
            state_n  = DISPATCH;
            pass_f_n = tgt;
            dir_n    = tgt_dir;
            butt_n   = 1'b1;
          end
        end
      end
      DISPATCH: begin
        state_n = WAIT_ACK;
        cnt_n   = '0;
      end
      WAIT_ACK: begin
        if (busy) begin
          state_n = TRAVEL;
        end else if (cnt_q >= CNT_LAST) begin
          state_n = DISPATCH;
          butt_n  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      TRAVEL: begin
        // The arrival floor is the served floor; elev_f == pass_f lands on the same bit.
        if (!busy && elev_ok) begin
          clr_mask = floor_oh;
          state_n  = ARRIVE;
        end
      end
      ARRIVE: begin
`ifdef LIFT_SCHED_DOOR_HOLD_EN
        state_n = HOLD;
        hold_n  = '0;
`else
        state_n = IDLE;
`endif
      end
`ifdef LIFT_SCHED_DOOR_HOLD_EN
      HOLD: begin
        clr_mask = floor_oh;
        if (hold_q >= HOLD_LAST) begin
          state_n = IDLE;
        end else begin
          hold_n = hold_q + HOLD_W'(1);
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    pending_n = (pending_q | hall_call | car_call) & ~clr_mask;
    idle_n    = (state_n == IDLE) && (pending_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      pass_f_q  <= '0;
      butt_q    <= 1'b0;
      dir_q     <= 1'b1;
      idle_q    <= 1'b1;
      cnt_q     <= '0;
`ifdef LIFT_SCHED_DOOR_HOLD_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_n;
      pending_q <= pending_n;
      pass_f_q  <= pass_f_n;
      butt_q    <= butt_n;
      dir_q     <= dir_n;
      idle_q    <= idle_n;
      cnt_q     <= cnt_n;
`ifdef LIFT_SCHED_DOOR_HOLD_EN
      hold_q    <= hold_n;
`endif
    end
  end

  assign pass_f       = pass_f_q;
  assign butt_up_down = butt_q;
  assign pending      = pending_q;
  assign dir_up       = dir_q;
  assign sched_idle   = idle_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: expected dispatches queued at stimulus, checked on each strobe.
module tb_lift_call_scheduler;

  localparam int unsigned NF  = 8;
  localparam int unsigned FW  = 3;
  localparam int unsigned ACK = 16;

  typedef struct packed {
    logic [FW-1:0] floor;
    logic          dir;
  } disp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] hall_call, car_call, pending;
  logic [FW-1:0] elev_f, pass_f;
  logic          busy, butt_up_down, dir_up, sched_idle;

  int    checks = 0;
  int    failures = 0;
  int    strobes = 0;
  int    cyc = 0;
  int    t0, s0;
  disp_t exp_q[$];
  disp_t mon_e;

  lift_call_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .ACK_TIMEOUT(ACK), .DOOR_HOLD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hall_call(hall_call), .car_call(car_call),
    .elev_f(elev_f), .busy(busy), .pass_f(pass_f), .butt_up_down(butt_up_down),
    .pending(pending), .dir_up(dir_up), .sched_idle(sched_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every strobe must match the oldest queued dispatch.
  always @(negedge clk) begin
    if (rst_n && butt_up_down) begin
      strobes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_strobe observed pass_f=%0d expected no strobe", pass_f);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert ({pass_f, dir_up} === {mon_e.floor, mon_e.dir}) else begin
          failures++;
          $error("FAIL dispatch observed pass_f=%0d dir_up=%0b expected pass_f=%0d dir_up=%0b",
                 pass_f, dir_up, mon_e.floor, mon_e.dir);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!butt_up_down && n < 40);
    checks++;
    assert (butt_up_down === 1'b1) else begin
      failures++;
      $error("FAIL %s_strobe observed=%0b expected=1 within %0d cycles", tag, butt_up_down, n);
    end
  endtask

  // Lift model: acknowledge a strobe, travel, arrive at floor.
  task automatic lift_serve(input logic [FW-1:0] floor, input int hops);
    busy = 1'b1;
    tick(hops + 2);
    check("pass_f_hold", 32'(pass_f), 32'(floor));
    elev_f = floor;
    busy   = 1'b0;
    tick(1);
    check("served_bit", 32'(pending[floor]), 32'd0);
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; hall_call = '0; car_call = '0; elev_f = '0; busy = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_butt", 32'(butt_up_down), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_idle", 32'(sched_idle), 32'd1);
    check("rst_pass_f", 32'(pass_f), 32'd0);

    // Single hall call at floor 3 from floor 0.
    hall_call = 8'h08;
    exp_q.push_back(disp_t'{3'd3, 1'b1});
    tick(1);
    hall_call = '0;
    check("single_latch", 32'(pending), 32'h08);
    check("single_not_idle", 32'(sched_idle), 32'd0);
    check("single_no_early", 32'(butt_up_down), 32'd0);
    tick(1);
    check("single_latency", 32'(butt_up_down), 32'd1);
    lift_serve(3'd3, 3);
    check("single_pending", 32'(pending), 32'd0);
    check("single_idle", 32'(sched_idle), 32'd1);

    // SCAN order from floor 2 going up: 5, 6, then reverse to 1.
    elev_f   = 3'd2;
    car_call = 8'h62;
    exp_q.push_back(disp_t'{3'd5, 1'b1});
    exp_q.push_back(disp_t'{3'd6, 1'b1});
    exp_q.push_back(disp_t'{3'd1, 1'b0});
    tick(1);
    car_call = '0;
    wait_strobe("scan5");
    lift_serve(3'd5, 2);
    wait_strobe("scan6");
    lift_serve(3'd6, 1);
    wait_strobe("scan1");
    check("scan_dir_flip", 32'(dir_up), 32'd0);
    lift_serve(3'd1, 4);
    check("scan_pending", 32'(pending), 32'd0);

    // Call at the lift's own floor is cleared with no dispatch.
    elev_f    = 3'd4;
    hall_call = 8'h10;
    s0        = strobes;
    tick(1);
    hall_call = '0;
    check("same_latch", 32'(pending), 32'h10);
    tick(1);
    check("same_clear", 32'(pending), 32'd0);
    check("same_idle", 32'(sched_idle), 32'd1);
    tick(3);
    check("same_no_strobe", 32'(strobes), 32'(s0));

    // Lift still busy: call waits in IDLE until busy drops.
    busy      = 1'b1;
    hall_call = 8'h01;
    exp_q.push_back(disp_t'{3'd0, 1'b0});
    s0        = strobes;
    tick(1);
    hall_call = '0;
    tick(4);
    check("busy_hold_pending", 32'(pending), 32'h01);
    check("busy_hold_no_strobe", 32'(strobes), 32'(s0));
    busy = 1'b0;
    wait_strobe("busy_release");
    lift_serve(3'd0, 1);

    // No busy after dispatch of 7: re-strobe every ACK+1 cycles.
    hall_call = 8'h80;
    repeat (3) exp_q.push_back(disp_t'{3'd7, 1'b1});
    tick(1);
    hall_call = '0;
    wait_strobe("ack0");
    t0 = cyc;
    wait_strobe("ack1");
    check("ack_period1", 32'(cyc - t0), 32'(ACK + 1));
    t0 = cyc;
    wait_strobe("ack2");
    check("ack_period2", 32'(cyc - t0), 32'(ACK + 1));
    lift_serve(3'd7, 2);
    check("ack_pending", 32'(pending), 32'd0);

    // Asynchronous reset mid-TRAVEL with floors 2 and 5 pending.
    hall_call = 8'h24;
    exp_q.push_back(disp_t'{3'd5, 1'b0});
    tick(1);
    hall_call = '0;
    wait_strobe("pre_reset");
    busy = 1'b1;
    tick(3);
    check("travel_pending", 32'(pending), 32'h24);
    #2 rst_n = 1'b0;
    #1;
    check("areset_pending", 32'(pending), 32'd0);
    check("areset_butt", 32'(butt_up_down), 32'd0);
    check("areset_idle", 32'(sched_idle), 32'd1);
    check("areset_dir", 32'(dir_up), 32'd1);
    @(negedge clk);
    busy  = 1'b0;
    rst_n = 1'b1;
    tick(2);
    check("post_reset_idle", 32'(sched_idle), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
